// File: rtl/tankb_pkg.sv
// Shared definitions for the Tank Battalion sound-effect player.
// Purpose: voice index constants, sequencer/voice state types, default
//          sample lengths and ROM offsets, and the PCM byte conversion.
// Ports:   none (package).
package tankb_pkg;

  // Voice indices, also the bit positions in the busy vector
  localparam int V_EXPLODE = 0;
  localparam int V_FIRE    = 1;

  // Sample ROM geometry: 128 KiB, byte addressed
  localparam int ROM_AW    = 17;
  localparam int ROM_BYTES = 1 << ROM_AW;

  // Defaults for the original board: 12 kHz sample rate from 18.432 MHz
  localparam int                DEF_SAMPLE_DIV   = 1536;
  localparam int                DEF_EXPLODE_LEN  = 52095;
  localparam int                DEF_FIRE_LEN     = 21791;
  localparam logic [ROM_AW-1:0] DEF_EXPLODE_BASE = 17'h00000;
  localparam logic [ROM_AW-1:0] DEF_FIRE_BASE    = 17'h0CC00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_V0,
    S_V1,
    S_MIX
  } seq_state_e;

  typedef enum logic {
    IDLE,
    PLAY
  } voice_state_e;

  // Offset-binary PCM byte to two's complement: flipping the MSB moves
  // the 0x80 midpoint to zero.
  function automatic logic signed [7:0] pcm_to_signed(input logic [7:0] b);
    return {~b[7], b[6:0]};
  endfunction

endpackage

// File: rtl/tankb_sfx_player_voice.sv
// sfx_voice: one playback voice of the sound-effect player.
// Purpose: rising-edge detection on the trigger, IDLE/PLAY state machine,
//          sample pointer and busy flag.
// Ports:
//   clk_i      - clock
//   rst_i      - asynchronous active-high reset
//   trig_i     - trigger level (latch bit); a rising edge (re)starts playback
//   tick_i     - a fetch of this voice's current sample is starting
//   mix_i      - the fetched sample is being mixed; advance the pointer
//   addr_o     - ROM byte address of the current sample (BASE + ptr)
//   busy_o     - voice is playing
//   fetched_o  - the sample in flight belongs to this playback (mix gate)
module sfx_voice
  import tankb_pkg::*;
#(
  parameter int                LEN  = DEF_EXPLODE_LEN,
  parameter logic [ROM_AW-1:0] BASE = DEF_EXPLODE_BASE
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              trig_i,
  input  logic              tick_i,
  input  logic              mix_i,
  output logic [ROM_AW-1:0] addr_o,
  output logic              busy_o,
  output logic              fetched_o
);

  localparam logic [ROM_AW-1:0] LAST = ROM_AW'(LEN - 1);

  if (LEN < 1 || LEN > ROM_BYTES) begin : g_bad_len
    $error("sfx_voice: LEN out of range");
  end

  voice_state_e      state_q;
  logic [ROM_AW-1:0] ptr_q;
  logic              trig_q;
  logic              fetched_q;
  logic              rise;

  assign rise = trig_i & ~trig_q;

  // A rise clears fetched_q so a retrigger landing inside a fetch neither
  // advances the freshly zeroed pointer nor mixes the stale byte.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trig_q    <= 1'b0;
      state_q   <= IDLE;
      ptr_q     <= '0;
      fetched_q <= 1'b0;
    end else begin
      trig_q <= trig_i;
      if (rise) begin
        state_q   <= PLAY;
        ptr_q     <= '0;
        fetched_q <= 1'b0;
      end else if (state_q == PLAY) begin
        if (tick_i) begin
          fetched_q <= 1'b1;
        end else if (mix_i && fetched_q) begin
          fetched_q <= 1'b0;
          if (ptr_q == LAST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
      end
    end
  end

  assign addr_o    = BASE + ptr_q;
  assign busy_o    = (state_q == PLAY);
  assign fetched_o = fetched_q;

endmodule

// File: rtl/tankb_sfx_player.sv
// tankb_sfx_player: two-voice PCM sample player for Tank Battalion effects.
// Purpose: plays the explosion and fire samples from a download-loaded ROM
//          on rising edges of the J4 latch bits and mixes both voices.
// Ports:
//   CLK_18M    - sole clock
//   RESET      - asynchronous active-high reset
//   pause      - freezes the sample clock, fetch sequencer and output
//   explode    - J4 explosion bit, rising edge starts voice 0
//   fire       - J4 fire bit, rising edge starts voice 1
//   dn_addr    - download byte address
//   dn_data    - download byte
//   dn_wr      - download write strobe
//   dn_sfx_cs  - download region select for the sample ROM
//   sound_out  - signed mixed sample, voices summed and scaled by 128
//   busy       - per-voice playing flags {fire, explode}
module tankb_sfx_player
  import tankb_pkg::*;
#(
  parameter int                SAMPLE_DIV  = DEF_SAMPLE_DIV,
  parameter int                EXPLODE_LEN = DEF_EXPLODE_LEN,
  parameter int                FIRE_LEN    = DEF_FIRE_LEN,
  parameter logic [ROM_AW-1:0] FIRE_BASE   = DEF_FIRE_BASE
) (
  input  logic                CLK_18M,
  input  logic                RESET,
  input  logic                pause,
  input  logic                explode,
  input  logic                fire,
  input  logic [ROM_AW-1:0]   dn_addr,
  input  logic [7:0]          dn_data,
  input  logic                dn_wr,
  input  logic                dn_sfx_cs,
  output logic signed [15:0]  sound_out,
  output logic [1:0]          busy
);

  localparam int              DIV_W    = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  // The fetch takes four cycles from the tick; a shorter period would let
  // a tick arrive while the sequencer is busy.
  if (SAMPLE_DIV < 4) begin : g_bad_div
    $error("tankb_sfx_player: SAMPLE_DIV must be at least 4");
  end
  if (int'(FIRE_BASE) + FIRE_LEN > ROM_BYTES) begin : g_bad_fire
    $error("tankb_sfx_player: fire sample exceeds ROM");
  end

  // Voices sum in 9 bits (no overflow possible), then scale to 16 bits.
  function automatic logic signed [15:0] mix_voices(input logic signed [7:0] s0,
                                                     input logic signed [7:0] s1);
    logic [8:0] sum;
    sum = {s0[7], s0} + {s1[7], s1};
    return {sum, 7'b0};
  endfunction

  logic [DIV_W-1:0]   div_q, div_d;
  logic               tick;
  seq_state_e         seq_q;
  logic               mix_stb;
  logic signed [15:0] sound_q;
  logic [7:0]         b0_q;
  logic [7:0]         rom_q;
  logic [ROM_AW-1:0]  rd_addr;
  logic [ROM_AW-1:0]  addr0, addr1;
  logic               busy0, busy1;
  logic               fetched0, fetched1;
  logic signed [7:0]  s0, s1;
  logic [7:0]         rom_mem [ROM_BYTES];

  // Sample-rate divider
  assign tick = ~pause && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    if (!pause) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_18M or posedge RESET) begin
    if (RESET) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // Voices
  assign mix_stb = (seq_q == S_MIX) && !pause;

  sfx_voice #(
    .LEN  (EXPLODE_LEN),
    .BASE (DEF_EXPLODE_BASE)
  ) u_voice_explode (
    .clk_i     (CLK_18M),
    .rst_i     (RESET),
    .trig_i    (explode),
    .tick_i    (tick),
    .mix_i     (mix_stb),
    .addr_o    (addr0),
    .busy_o    (busy0),
    .fetched_o (fetched0)
  );

  sfx_voice #(
    .LEN  (FIRE_LEN),
    .BASE (FIRE_BASE)
  ) u_voice_fire (
    .clk_i     (CLK_18M),
    .rst_i     (RESET),
    .trig_i    (fire),
    .tick_i    (tick),
    .mix_i     (mix_stb),
    .addr_o    (addr1),
    .busy_o    (busy1),
    .fetched_o (fetched1)
  );

  // Sample ROM: port B download writes, port A registered reads
  assign rd_addr = (seq_q == S_V0) ? addr0 : addr1;

  always_ff @(posedge CLK_18M) begin
    if (dn_wr && dn_sfx_cs) begin
      rom_mem[dn_addr] <= dn_data;
    end
  end

  // The read is held during pause so the byte in flight survives the stall.
  always_ff @(posedge CLK_18M) begin
    if (!pause) begin
      rom_q <= rom_mem[rd_addr];
    end
  end

  // Fetch sequencer: V0 presents voice 0, V1 captures it and presents
  // voice 1, MIX captures voice 1 and registers the mix.
  always_ff @(posedge CLK_18M or posedge RESET) begin
    if (RESET) begin
      seq_q   <= S_IDLE;
      sound_q <= '0;
    end else if (!pause) begin
      case (seq_q)
        S_IDLE: if (tick) seq_q <= S_V0;
        S_V0:   seq_q <= S_V1;
        S_V1:   seq_q <= S_MIX;
        S_MIX: begin
          seq_q   <= S_IDLE;
          sound_q <= mix_voices(s0, s1);
        end
        default: seq_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_18M) begin
    if (!pause && seq_q == S_V1) begin
      b0_q <= rom_q;
    end
  end

  // An idle voice contributes silence, not the offset-binary midpoint.
  assign s0 = fetched0 ? pcm_to_signed(b0_q)  : 8'sd0;
  assign s1 = fetched1 ? pcm_to_signed(rom_q) : 8'sd0;

  assign sound_out         = sound_q;
  assign busy[V_EXPLODE]   = busy0;
  assign busy[V_FIRE]      = busy1;

endmodule

// File: tb/tb_tankb_sfx_player.sv
// Directed testbench for tankb_sfx_player with a short sample period and
// short samples. A local divider model predicts the edge on which each
// mixed sample appears; expected outputs are hand-computed constants.
module tb_tankb_sfx_player;

  localparam int          DIV   = 8;
  localparam int          ELEN  = 3;
  localparam int          FLEN  = 4;
  localparam logic [16:0] FBASE = 17'h00010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pause = 1'b0;
  logic        explode = 1'b0;
  logic        fire = 1'b0;
  logic [16:0] dn_addr = '0;
  logic [7:0]  dn_data = '0;
  logic        dn_wr = 1'b0;
  logic        dn_sfx_cs = 1'b0;
  logic [15:0] sound_out;
  logic [1:0]  busy;

  int n_cmp = 0;
  int n_bad = 0;

  int         bdiv;
  logic [3:0] tick_sr;

  always #5 clk = ~clk;

  tankb_sfx_player #(
    .SAMPLE_DIV  (DIV),
    .EXPLODE_LEN (ELEN),
    .FIRE_LEN    (FLEN),
    .FIRE_BASE   (FBASE)
  ) dut (
    .CLK_18M   (clk),
    .RESET     (rst),
    .pause     (pause),
    .explode   (explode),
    .fire      (fire),
    .dn_addr   (dn_addr),
    .dn_data   (dn_data),
    .dn_wr     (dn_wr),
    .dn_sfx_cs (dn_sfx_cs),
    .sound_out (sound_out),
    .busy      (busy)
  );

  // Expected sample timing: tick when divider is at DIV-1, output lands
  // three clocks after the edge that ends the tick cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bdiv    <= 0;
      tick_sr <= '0;
    end else if (!pause) begin
      tick_sr <= {tick_sr[2:0], (bdiv == DIV - 1)};
      bdiv    <= (bdiv == DIV - 1) ? 0 : bdiv + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic align();
    bit ok = 1'b0;
    for (int i = 0; i < 4 * DIV; i++) begin
      if (bdiv == 4 && tick_sr == 4'd0) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL align: sample slot not found within budget");
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] exp);
    bit ok = 1'b0;
    for (int i = 0; i < 4 * DIV + 8; i++) begin
      step(1);
      if (tick_sr[3]) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      check_val(tag, {16'h0, sound_out}, {16'h0, exp});
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no sample update within budget, got %h expected %h",
               tag, sound_out, exp);
    end
  endtask

  task automatic dl(input logic [16:0] a, input logic [7:0] d, input logic cs);
    dn_addr   = a;
    dn_data   = d;
    dn_wr     = 1'b1;
    dn_sfx_cs = cs;
    step(1);
    dn_wr     = 1'b0;
    dn_sfx_cs = 1'b0;
  endtask

  int changed;
  int loud;

  initial begin
    step(2);
    check_val("reset_sound", {16'h0, sound_out}, 32'h0);
    check_val("reset_busy", {30'h0, busy}, 32'h0);

    // explosion 80 FF 00, fire FF FF 01 02
    dl(17'h00000, 8'h80, 1'b1);
    dl(17'h00001, 8'hFF, 1'b1);
    dl(17'h00002, 8'h00, 1'b1);
    dl(FBASE + 17'd0, 8'hFF, 1'b1);
    dl(FBASE + 17'd1, 8'hFF, 1'b1);
    dl(FBASE + 17'd2, 8'h01, 1'b1);
    dl(FBASE + 17'd3, 8'h02, 1'b1);
    dl(17'h00001, 8'h00, 1'b0);  // not selected: must not land
    rst = 1'b0;

    // single explosion
    align();
    explode = 1'b1;
    step(1);
    check_val("t1_busy_on", {30'h0, busy}, 32'h1);
    explode = 1'b0;
    expect_out("t1_s0", 16'h0000);
    expect_out("t1_s1", 16'h3F80);
    expect_out("t1_s2", 16'hC000);
    check_val("t1_busy_off", {30'h0, busy}, 32'h0);
    expect_out("t1_silent", 16'h0000);

    // both voices on the same tick
    align();
    explode = 1'b1;
    fire    = 1'b1;
    step(1);
    check_val("t2_busy_on", {30'h0, busy}, 32'h3);
    explode = 1'b0;
    fire    = 1'b0;
    expect_out("t2_s0", 16'h3F80);
    expect_out("t2_s1", 16'h7F00);
    expect_out("t2_s2", 16'h8080);
    check_val("t2_busy_fire", {30'h0, busy}, 32'h2);
    expect_out("t2_s3", 16'hC100);
    check_val("t2_busy_off", {30'h0, busy}, 32'h0);

    // retrigger at ptr 2
    align();
    explode = 1'b1;
    step(1);
    explode = 1'b0;
    expect_out("t3_s0", 16'h0000);
    expect_out("t3_s1", 16'h3F80);
    align();
    explode = 1'b1;
    step(1);
    explode = 1'b0;
    check_val("t3_busy_retrig", {30'h0, busy}, 32'h1);
    expect_out("t3_restart", 16'h0000);
    check_val("t3_busy_mid", {30'h0, busy}, 32'h1);
    expect_out("t3_r1", 16'h3F80);
    expect_out("t3_r2", 16'hC000);
    check_val("t3_busy_off", {30'h0, busy}, 32'h0);

    // fire held high for 5*LEN ticks plays once
    align();
    fire = 1'b1;
    expect_out("t4_s0", 16'h3F80);
    expect_out("t4_s1", 16'h3F80);
    expect_out("t4_s2", 16'hC080);
    expect_out("t4_s3", 16'hC100);
    check_val("t4_busy_done", {30'h0, busy}, 32'h0);
    loud = 0;
    for (int i = 0; i < 4 * FLEN; i++) begin
      expect_out("t4_quiet", 16'h0000);
    end
    check_val("t4_busy_held", {30'h0, busy}, 32'h0);
    fire = 1'b0;

    // pause mid-sample for 20 ticks
    align();
    explode = 1'b1;
    step(1);
    explode = 1'b0;
    expect_out("t5_s0", 16'h0000);
    expect_out("t5_s1", 16'h3F80);
    pause   = 1'b1;
    changed = 0;
    for (int i = 0; i < 20 * DIV; i++) begin
      step(1);
      if (sound_out !== 16'h3F80 || busy !== 2'b01) changed++;
    end
    check_val("t5_frozen", changed, 0);
    pause = 1'b0;
    expect_out("t5_resume", 16'hC000);
    check_val("t5_busy_off", {30'h0, busy}, 32'h0);

    // rise during pause arms at ptr 0, starts when pause falls
    align();
    pause   = 1'b1;
    explode = 1'b1;
    step(1);
    explode = 1'b0;
    check_val("t5b_armed", {30'h0, busy}, 32'h1);
    step(30);
    check_val("t5b_hold_out", {16'h0, sound_out}, 32'h0000C000);
    pause = 1'b0;
    expect_out("t5b_s0", 16'h0000);
    expect_out("t5b_s1", 16'h3F80);
    expect_out("t5b_s2", 16'hC000);

    // reset mid-playback with explode held high
    align();
    explode = 1'b1;
    expect_out("t6_s0", 16'h0000);
    expect_out("t6_s1", 16'h3F80);
    #3;
    rst = 1'b1;
    #1;
    check_val("t6_rst_sound", {16'h0, sound_out}, 32'h0);
    check_val("t6_rst_busy", {30'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1);
    check_val("t6_rise_busy", {30'h0, busy}, 32'h1);
    expect_out("t6_r0", 16'h0000);
    expect_out("t6_r1", 16'h3F80);
    expect_out("t6_r2", 16'hC000);
    check_val("t6_busy_off", {30'h0, busy}, 32'h0);
    explode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
